// File: rtl/mem_stage_responder.sv
// mem_stage_responder: responder end of the MEM-stage data-memory port.
// Each 32-bit access is split into two half-word accesses to an internal
// 16-bit SRAM model, each WAIT_CYCLES long; ready stays low while an access
// is in flight so the pipeline freezes.
// Optional macro MEM_WRITE_BUFFER_EN: valid writes are posted (ready=1 in the
// request cycle) and drained in the background, skipping DONE; reads unchanged.
module mem_stage_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2,   // legal 1..15
  parameter int unsigned BASE_ADDR   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        addr_err
);

  localparam int unsigned IW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned HW    = IW + 1;
  localparam logic [3:0]  WLAST = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_e;

  state_e          state_q, state_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic [IW-1:0]   a_idx_q, a_idx_d;
  logic            a_wr_q, a_wr_d;
  logic [31:0]     a_data_q, a_data_d;
  logic [31:0]     read_data_q, read_data_d;
  logic            addr_err_q, addr_err_d;

  logic [15:0]     mem_q [2*DEPTH_WORDS];

  // Request decode: word index relative to BASE_ADDR and the bad-address flag.
  logic            req_any;
  logic [29:0]     idx_w;
  logic            bad;
  logic            busy;
  logic            half_last;
  logic [HW-1:0]   hw_addr;
  logic [15:0]     mem_rdata;
  logic            mem_we;
  logic [15:0]     mem_wdata;

  assign req_any   = req_read | req_write;
  assign idx_w     = 30'((address - BASE_ADDR) >> 2);
  assign bad       = (address[1:0] != 2'b00) || (address < BASE_ADDR) ||
                     (idx_w >= 30'(DEPTH_WORDS));
  assign busy      = (state_q == LOW) || (state_q == HIGH);
  assign half_last = (wcnt_q == WLAST);
  assign hw_addr   = {a_idx_q, state_q == HIGH};
  assign mem_rdata = mem_q[hw_addr];
  // A reset on the completing cycle aborts that half as well.
  assign mem_we    = busy && half_last && a_wr_q && !rst;
  assign mem_wdata = (state_q == HIGH) ? a_data_q[31:16] : a_data_q[15:0];

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          if (bad) begin
`ifdef MEM_WRITE_BUFFER_EN
            state_d = req_write ? IDLE : DONE;
`else
            state_d = DONE;
`endif
          end else begin
            state_d = LOW;
          end
        end
      end
      LOW:  if (half_last) state_d = HIGH;
      HIGH: begin
        if (half_last) begin
`ifdef MEM_WRITE_BUFFER_EN
          state_d = a_wr_q ? IDLE : DONE;
`else
          state_d = DONE;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: ready when idle with nothing pending, or completing in DONE.
  always_comb begin
    ready = 1'b0;
    case (state_q)
`ifdef MEM_WRITE_BUFFER_EN
      IDLE:    ready = !req_any || req_write;
`else
      IDLE:    ready = !req_any;
`endif
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Datapath next-state: request latches, wait counter, read assembly, error flag.
  always_comb begin
    wcnt_d      = wcnt_q;
    a_idx_d     = a_idx_q;
    a_wr_d      = a_wr_q;
    a_data_d    = a_data_q;
    read_data_d = read_data_q;
    addr_err_d  = addr_err_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          a_idx_d     = idx_w[IW-1:0];
          a_wr_d      = req_write;
          a_data_d    = write_data;
          read_data_d = '0;
          wcnt_d      = '0;
          addr_err_d  = bad;
`ifdef MEM_WRITE_BUFFER_EN
          if (req_write) addr_err_d = 1'b0;
`endif
        end
      end
      LOW, HIGH: begin
        if (half_last) begin
          wcnt_d = '0;
          if (!a_wr_q) begin
            if (state_q == LOW) read_data_d[15:0]  = mem_rdata;
            else                read_data_d[31:16] = mem_rdata;
          end
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end
      DONE:    addr_err_d = 1'b0;
      default: ;
    endcase
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q      <= '0;
      a_idx_q     <= '0;
      a_wr_q      <= 1'b0;
      a_data_q    <= '0;
      read_data_q <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      wcnt_q      <= wcnt_d;
      a_idx_q     <= a_idx_d;
      a_wr_q      <= a_wr_d;
      a_data_q    <= a_data_d;
      read_data_q <= read_data_d;
      addr_err_q  <= addr_err_d;
    end
  end

  // Half-word SRAM write port.
  // NOTE: the storage array has no reset; its contents survive rst like a real SRAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[hw_addr] <= mem_wdata;
  end

  assign read_data = read_data_q;
  assign addr_err  = addr_err_q;

endmodule
